vfu_result_wb: RTL and testbench
================================

VFU_RESULT_WB -- requirements
Module: vfu_result_wb

Interface
REQ-001 Parameter DataWidth, default 64, SHALL set the result data width in bits; byte-enable width is DataWidth/8.
REQ-002 Parameter AddrWidth, default 10, SHALL set the VRF write-address width.
REQ-003 Parameter IdWidth, default 3, SHALL set the vector-instruction id width.
REQ-004 Parameter Depth, default 2, SHALL set the per-source FIFO depth; legal values are 2..8.
REQ-005 The clock SHALL be clk_i, input, 1 bit; all state updates occur on its rising edge.
REQ-006 The reset SHALL be rst_i, input, 1 bit, synchronous and active-high.
REQ-007 alu_result_req_i/id_i/addr_i/wdata_i/be_i SHALL be inputs (1/IdWidth/AddrWidth/DataWidth/DataWidth/8 bits) carrying the ALU write request.
REQ-008 alu_result_gnt_o SHALL be a 1-bit output accepting the ALU request.
REQ-009 mfpu_result_req_i/id_i/addr_i/wdata_i/be_i and mfpu_result_gnt_o SHALL be identical in shape to the ALU group, for the MFPU.
REQ-010 vrf_req_o/id_o/addr_o/wdata_o/be_o SHALL be outputs presenting one write to the VRF write port.
REQ-011 vrf_src_o SHALL be a 1-bit output: 0 = ALU entry, 1 = MFPU entry.
REQ-012 vrf_gnt_i SHALL be a 1-bit input; the VRF accepts the write when vrf_req_o and vrf_gnt_i are both high.
REQ-013 alu_cnt_o and mfpu_cnt_o SHALL be outputs of width clog2(Depth+1) giving the FIFO occupancy.

Function
REQ-014 Each source SHALL own a Depth-entry FIFO storing {id, addr, wdata, be}.
REQ-015 Source gnt_o SHALL equal req_i AND (cnt < Depth), combinationally in the same cycle; a push occurs on req_i && gnt_o.
- A full FIFO refuses pushes even if it pops in that cycle.
REQ-016 vrf_req_o SHALL be high whenever either FIFO is non-empty.
REQ-017 The vrf_* data outputs SHALL be the head of the selected FIFO, driven through a mux with no register on the path.
- Minimum latency from source handshake to vrf_req_o is 1 cycle.
REQ-018 Selection SHALL follow a one-bit round-robin pointer rr (0 = ALU preferred).
- If only one FIFO is non-empty, it is selected.
- If both are non-empty, the FIFO indicated by rr is selected.
REQ-019 The selection SHALL be locked while vrf_req_o && !vrf_gnt_i.
- A locked selection keeps vrf_src_o and all vrf_* data stable until the grant, even if the other FIFO becomes non-empty.
REQ-020 On vrf_req_o && vrf_gnt_i the selected FIFO SHALL pop.
- rr then becomes the inverse of vrf_src_o, but only if the other FIFO is non-empty at that edge; otherwise rr is unchanged.
REQ-021 A simultaneous push and pop on one FIFO SHALL leave cnt unchanged and preserve FIFO order.
REQ-022 Read and write pointers SHALL wrap modulo Depth.
REQ-023 vrf_gnt_i while vrf_req_o is low SHALL have no effect.
REQ-024 Entries SHALL leave each FIFO in push order; no entry is dropped or duplicated.

Reset
REQ-025 While rst_i is high at a clock edge, both FIFOs SHALL empty, the lock SHALL clear and rr SHALL become 0.
- Entries in flight, including a locked unaccepted write, are discarded.
REQ-026 During and after reset, vrf_req_o, vrf_src_o, alu_cnt_o and mfpu_cnt_o SHALL be 0, and vrf data outputs SHALL be 0 while vrf_req_o is 0.
REQ-027 Source gnt_o SHALL be 0 in any cycle where rst_i is high.

Verification
REQ-028 Single ALU write: addr=5, wdata=0xDEAD, be=0xFF in cycle 0 with vrf_gnt_i=1 -> alu_result_gnt_o=1 in cycle 0; vrf_req_o=1, addr_o=5, src_o=0 in cycle 1; cnt=0 in cycle 2.
REQ-029 Fill ALU with 3 pushes and vrf_gnt_i=0 -> gnt_o=1,1,0; alu_cnt_o=2; after releasing the grant, addresses exit in push order.
REQ-030 Both FIFOs hold 2 entries with vrf_gnt_i=1 -> vrf_src_o sequence 0,1,0,1.
REQ-031 MFPU locked with grant held low for 3 cycles while ALU pushes -> src_o stays 1 and data is stable; after the grant the next src_o is 0.
REQ-032 Reset asserted with 2 entries queued and vrf_req_o high -> next cycle vrf_req_o=0, both cnt=0; the first post-reset push emerges with src_o matching its source.

Source files
------------

// File: rtl/vfu_result_wb_if.sv
// rtl/vfu_result_wb_if.sv - ALU/MFPU result requests, VRF write port and occupancy for vfu_result_wb
interface vfu_result_wb_if #(
  parameter int DataWidth = 64,
  parameter int AddrWidth = 10,
  parameter int IdWidth   = 3,
  parameter int Depth     = 2
);
  localparam int BeWidth  = DataWidth / 8;
  localparam int CntWidth = $clog2(Depth + 1);

  logic                 alu_result_req_i;
  logic [IdWidth-1:0]   alu_result_id_i;
  logic [AddrWidth-1:0] alu_result_addr_i;
  logic [DataWidth-1:0] alu_result_wdata_i;
  logic [BeWidth-1:0]   alu_result_be_i;
  logic                 alu_result_gnt_o;

  logic                 mfpu_result_req_i;
  logic [IdWidth-1:0]   mfpu_result_id_i;
  logic [AddrWidth-1:0] mfpu_result_addr_i;
  logic [DataWidth-1:0] mfpu_result_wdata_i;
  logic [BeWidth-1:0]   mfpu_result_be_i;
  logic                 mfpu_result_gnt_o;

  logic                 vrf_req_o;
  logic [IdWidth-1:0]   vrf_id_o;
  logic [AddrWidth-1:0] vrf_addr_o;
  logic [DataWidth-1:0] vrf_wdata_o;
  logic [BeWidth-1:0]   vrf_be_o;
  logic                 vrf_src_o;
  logic                 vrf_gnt_i;

  logic [CntWidth-1:0]  alu_cnt_o;
  logic [CntWidth-1:0]  mfpu_cnt_o;

  modport slave (
    input  alu_result_req_i, alu_result_id_i, alu_result_addr_i, alu_result_wdata_i, alu_result_be_i,
    output alu_result_gnt_o,
    input  mfpu_result_req_i, mfpu_result_id_i, mfpu_result_addr_i, mfpu_result_wdata_i, mfpu_result_be_i,
    output mfpu_result_gnt_o,
    output vrf_req_o, vrf_id_o, vrf_addr_o, vrf_wdata_o, vrf_be_o, vrf_src_o,
    input  vrf_gnt_i,
    output alu_cnt_o, mfpu_cnt_o
  );

  modport master (
    output alu_result_req_i, alu_result_id_i, alu_result_addr_i, alu_result_wdata_i, alu_result_be_i,
    input  alu_result_gnt_o,
    output mfpu_result_req_i, mfpu_result_id_i, mfpu_result_addr_i, mfpu_result_wdata_i, mfpu_result_be_i,
    input  mfpu_result_gnt_o,
    input  vrf_req_o, vrf_id_o, vrf_addr_o, vrf_wdata_o, vrf_be_o, vrf_src_o,
    output vrf_gnt_i,
    input  alu_cnt_o, mfpu_cnt_o
  );
endinterface

// File: rtl/vfu_result_wb.sv
// rtl/vfu_result_wb.sv - two-source result FIFOs with round-robin arbitration onto one VRF write port
module vfu_result_wb #(
  parameter int DataWidth = 64,
  parameter int AddrWidth = 10,
  parameter int IdWidth   = 3,
  parameter int Depth     = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  vfu_result_wb_if.slave bus
);
  localparam int BeWidth  = DataWidth / 8;
  localparam int CntWidth = $clog2(Depth + 1);
  localparam int PtrW     = $clog2(Depth);
  localparam int EntryW   = IdWidth + AddrWidth + DataWidth + BeWidth;

  // Index 0 is the ALU source, index 1 the MFPU source.
  logic [EntryW-1:0]   mem [2][Depth];
  logic [PtrW-1:0]     wr_ptr [2];
  logic [PtrW-1:0]     rd_ptr [2];
  logic [CntWidth-1:0] cnt [2];
  logic [EntryW-1:0]   entry_in [2];
  logic [1:0]          req_in;
  logic [1:0]          ne;
  logic [1:0]          push;
  logic [1:0]          pop;
  logic                req_any;
  logic                sel;
  logic                rr;
  logic                locked;
  logic                lock_src;
  logic [EntryW-1:0]   head;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    entry_in[0] = {bus.alu_result_id_i, bus.alu_result_addr_i,
                   bus.alu_result_wdata_i, bus.alu_result_be_i};
    entry_in[1] = {bus.mfpu_result_id_i, bus.mfpu_result_addr_i,
                   bus.mfpu_result_wdata_i, bus.mfpu_result_be_i};
    req_in      = {bus.mfpu_result_req_i, bus.alu_result_req_i};
    ne          = {cnt[1] != '0, cnt[0] != '0};
    req_any     = !rst_i && (ne != 2'b00);

    // A held (ungranted) write keeps its source; otherwise rr breaks ties.
    if (locked)          sel = lock_src;
    else if (&ne)        sel = rr;
    else                 sel = ne[1];

    for (int s = 0; s < 2; s++) begin
      push[s] = !rst_i && req_in[s] && (cnt[s] < CntWidth'(Depth));
    end
    pop[0] = req_any && bus.vrf_gnt_i && !sel;
    pop[1] = req_any && bus.vrf_gnt_i &&  sel;
    head   = mem[sel][rd_ptr[sel]];
  end

  assign bus.alu_result_gnt_o  = push[0];
  assign bus.mfpu_result_gnt_o = push[1];
  assign bus.vrf_req_o         = req_any;
  assign bus.vrf_src_o         = req_any & sel;
  assign {bus.vrf_id_o, bus.vrf_addr_o, bus.vrf_wdata_o, bus.vrf_be_o} = req_any ? head : '0;
  assign bus.alu_cnt_o         = rst_i ? '0 : cnt[0];
  assign bus.mfpu_cnt_o        = rst_i ? '0 : cnt[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        cnt[s]    <= '0;
      end
      rr       <= 1'b0;
      locked   <= 1'b0;
      lock_src <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) begin
          mem[s][wr_ptr[s]] <= entry_in[s];
          wr_ptr[s]         <= next_ptr(wr_ptr[s]);
        end
        if (pop[s]) rd_ptr[s] <= next_ptr(rd_ptr[s]);
        if (push[s] && !pop[s])      cnt[s] <= cnt[s] + 1'b1;
        else if (pop[s] && !push[s]) cnt[s] <= cnt[s] - 1'b1;
      end
      locked   <= req_any && !bus.vrf_gnt_i;
      lock_src <= sel;
      if ((pop != 2'b00) && ne[~sel]) rr <= ~sel;
    end
  end
endmodule

// File: tb/tb_vfu_result_wb.sv
// tb/tb_vfu_result_wb.sv - vector table, lock sequence and randomized queue-model check of vfu_result_wb
module tb_vfu_result_wb;
  localparam int DW = 64, AW = 10, IW = 3, D = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vfu_result_wb_if #(.DataWidth(DW), .AddrWidth(AW), .IdWidth(IW), .Depth(D)) bus ();
  vfu_result_wb #(.DataWidth(DW), .AddrWidth(AW), .IdWidth(IW), .Depth(D)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic r, ar; logic [AW-1:0] aa; logic [DW-1:0] aw;
    logic mr;    logic [AW-1:0] ma; logic [DW-1:0] mw;
    logic g;
    logic e_agnt, e_mgnt, e_vreq, e_src;
    logic [AW-1:0] e_addr; logic [DW-1:0] e_wdata;
    logic [1:0] e_acnt, e_mcnt;
  } vec_t;
  vec_t tbl[$];

  typedef struct packed {
    logic [IW-1:0] id; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW/8-1:0] be;
  } ent_t;
  ent_t aq[$], mq[$];
  bit rr_m, held_m, held_src_m;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, ar, input logic [AW-1:0] aa, input logic [DW-1:0] aw,
                     input logic mr, input logic [AW-1:0] ma, input logic [DW-1:0] mw,
                     input logic g, input logic ea, em, ev, es,
                     input logic [AW-1:0] eaddr, input logic [DW-1:0] ewd,
                     input logic [1:0] eac, emc);
    vec_t v;
    v = '{r, ar, aa, aw, mr, ma, mw, g, ea, em, ev, es, eaddr, ewd, eac, emc};
    tbl.push_back(v);
  endtask

  task automatic set_in(input logic r, ar, input logic [AW-1:0] aa, input logic [DW-1:0] aw,
                        input logic mr, input logic [AW-1:0] ma, input logic [DW-1:0] mw,
                        input logic g);
    @(posedge clk); #1;
    rst = r;
    bus.alu_result_req_i  = ar; bus.alu_result_addr_i  = aa; bus.alu_result_wdata_i  = aw;
    bus.alu_result_id_i   = aa[IW-1:0]; bus.alu_result_be_i  = 8'hFF;
    bus.mfpu_result_req_i = mr; bus.mfpu_result_addr_i = ma; bus.mfpu_result_wdata_i = mw;
    bus.mfpu_result_id_i  = ma[IW-1:0]; bus.mfpu_result_be_i = 8'hFF;
    bus.vrf_gnt_i = g;
    @(negedge clk);
  endtask

  task automatic expect_vrf(input string nm, input logic src, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd);
    chk({nm, "_req"}, bus.vrf_req_o, 1'b1);
    chk({nm, "_src"}, bus.vrf_src_o, src);
    chk({nm, "_addr"}, bus.vrf_addr_o, addr);
    chk({nm, "_wdata"}, bus.vrf_wdata_o, wd);
  endtask

  initial begin
    bus.alu_result_req_i = 0; bus.alu_result_id_i = 0; bus.alu_result_addr_i = 0;
    bus.alu_result_wdata_i = 0; bus.alu_result_be_i = 0;
    bus.mfpu_result_req_i = 0; bus.mfpu_result_id_i = 0; bus.mfpu_result_addr_i = 0;
    bus.mfpu_result_wdata_i = 0; bus.mfpu_result_be_i = 0;
    bus.vrf_gnt_i = 0;

    // r ar aa aw  mr ma mw  g | agnt mgnt vreq src addr wdata acnt mcnt
    add(1,1, 0,0,        0, 0,0,        0, 0,0,0,0,  0,0,        0,0);
    add(0,1, 5,'hDEAD,   0, 0,0,        1, 1,0,0,0,  0,0,        0,0);
    add(0,0, 0,0,        0, 0,0,        1, 0,0,1,0,  5,'hDEAD,   1,0);
    add(0,0, 0,0,        0, 0,0,        1, 0,0,0,0,  0,0,        0,0);
    add(0,1, 1,'hA001,   0, 0,0,        0, 1,0,0,0,  0,0,        0,0);
    add(0,1, 2,'hA002,   0, 0,0,        0, 1,0,1,0,  1,'hA001,   1,0);
    add(0,1, 3,'hA003,   0, 0,0,        0, 0,0,1,0,  1,'hA001,   2,0);
    add(0,0, 0,0,        0, 0,0,        1, 0,0,1,0,  1,'hA001,   2,0);
    add(0,0, 0,0,        0, 0,0,        1, 0,0,1,0,  2,'hA002,   1,0);
    add(0,0, 0,0,        0, 0,0,        1, 0,0,0,0,  0,0,        0,0);
    add(0,1,10,'hA00A,   1,20,'hB014,   0, 1,1,0,0,  0,0,        0,0);
    add(0,1,11,'hA00B,   1,21,'hB015,   0, 1,1,1,0, 10,'hA00A,   1,1);
    add(0,0, 0,0,        0, 0,0,        1, 0,0,1,0, 10,'hA00A,   2,2);
    add(0,0, 0,0,        0, 0,0,        1, 0,0,1,1, 20,'hB014,   1,2);
    add(0,0, 0,0,        0, 0,0,        1, 0,0,1,0, 11,'hA00B,   1,1);
    add(0,0, 0,0,        0, 0,0,        1, 0,0,1,1, 21,'hB015,   0,1);
    add(0,0, 0,0,        0, 0,0,        1, 0,0,0,0,  0,0,        0,0);
    add(0,1,30,'hA01E,   1,40,'hB028,   0, 1,1,0,0,  0,0,        0,0);
    add(0,0, 0,0,        0, 0,0,        0, 0,0,1,1, 40,'hB028,   1,1);
    add(1,1,31,'hA01F,   0, 0,0,        0, 0,0,0,0,  0,0,        0,0);
    add(0,0, 0,0,        1,50,'hB032,   0, 0,1,0,0,  0,0,        0,0);
    add(0,0, 0,0,        0, 0,0,        1, 0,0,1,1, 50,'hB032,   0,1);
    add(0,0, 0,0,        0, 0,0,        1, 0,0,0,0,  0,0,        0,0);
    add(0,1,60,'hA03C,   1,70,'hB046,   0, 1,1,0,0,  0,0,        0,0);
    add(0,0, 0,0,        0, 0,0,        1, 0,0,1,0, 60,'hA03C,   1,1);
    add(0,0, 0,0,        0, 0,0,        1, 0,0,1,1, 70,'hB046,   0,1);
    add(0,0, 0,0,        0, 0,0,        1, 0,0,0,0,  0,0,        0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].r, tbl[i].ar, tbl[i].aa, tbl[i].aw, tbl[i].mr, tbl[i].ma, tbl[i].mw, tbl[i].g);
      chk($sformatf("v%0d_agnt", i),  bus.alu_result_gnt_o,  tbl[i].e_agnt);
      chk($sformatf("v%0d_mgnt", i),  bus.mfpu_result_gnt_o, tbl[i].e_mgnt);
      chk($sformatf("v%0d_vreq", i),  bus.vrf_req_o,         tbl[i].e_vreq);
      chk($sformatf("v%0d_src", i),   bus.vrf_src_o,         tbl[i].e_src);
      chk($sformatf("v%0d_addr", i),  bus.vrf_addr_o,        tbl[i].e_addr);
      chk($sformatf("v%0d_wdata", i), bus.vrf_wdata_o,       tbl[i].e_wdata);
      chk($sformatf("v%0d_acnt", i),  bus.alu_cnt_o,         tbl[i].e_acnt);
      chk($sformatf("v%0d_mcnt", i),  bus.mfpu_cnt_o,        tbl[i].e_mcnt);
    end

    // MFPU write held ungranted for 3 cycles while the ALU queues up behind it.
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 1, 80, 'hB050, 0);
    chk("lk_mgnt", bus.mfpu_result_gnt_o, 1'b1);
    set_in(0, 1, 90, 'hA05A, 0, 0, 0, 0);
    expect_vrf("lk1", 1'b1, 80, 'hB050);
    chk("lk1_agnt", bus.alu_result_gnt_o, 1'b1);
    set_in(0, 1, 91, 'hA05B, 0, 0, 0, 0);
    expect_vrf("lk2", 1'b1, 80, 'hB050);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    expect_vrf("lk3", 1'b1, 80, 'hB050);
    chk("lk3_acnt", bus.alu_cnt_o, 2'd2);
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    expect_vrf("lk4", 1'b1, 80, 'hB050);
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    expect_vrf("lk5", 1'b0, 90, 'hA05A);

    // Randomized traffic against a queue-level reference model.
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    aq.delete(); mq.delete(); rr_m = 0; held_m = 0; held_src_m = 0;
    for (int c = 0; c < 1500; c++) begin
      logic vreq_e, s, agnt_e, mgnt_e, other_ne;
      ent_t hd, a_in, m_in;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 79) == 0);
      bus.alu_result_req_i  = ($urandom_range(0, 9) < 6);
      bus.mfpu_result_req_i = ($urandom_range(0, 9) < 5);
      bus.alu_result_id_i   = IW'($urandom);  bus.mfpu_result_id_i   = IW'($urandom);
      bus.alu_result_addr_i = AW'($urandom);  bus.mfpu_result_addr_i = AW'($urandom);
      bus.alu_result_wdata_i  = {$urandom, $urandom};
      bus.mfpu_result_wdata_i = {$urandom, $urandom};
      bus.alu_result_be_i   = 8'($urandom);   bus.mfpu_result_be_i   = 8'($urandom);
      bus.vrf_gnt_i = ($urandom_range(0, 9) < 5);
      @(negedge clk);
      a_in = '{bus.alu_result_id_i, bus.alu_result_addr_i, bus.alu_result_wdata_i, bus.alu_result_be_i};
      m_in = '{bus.mfpu_result_id_i, bus.mfpu_result_addr_i, bus.mfpu_result_wdata_i, bus.mfpu_result_be_i};
      vreq_e = !rst && (aq.size() > 0 || mq.size() > 0);
      if (held_m)                          s = held_src_m;
      else if (aq.size() > 0 && mq.size() > 0) s = rr_m;
      else                                 s = (mq.size() > 0);
      hd = '0;
      if (vreq_e) hd = s ? mq[0] : aq[0];
      agnt_e = !rst && bus.alu_result_req_i  && (aq.size() < D);
      mgnt_e = !rst && bus.mfpu_result_req_i && (mq.size() < D);
      chk("r_agnt",  bus.alu_result_gnt_o,  agnt_e);
      chk("r_mgnt",  bus.mfpu_result_gnt_o, mgnt_e);
      chk("r_vreq",  bus.vrf_req_o,         vreq_e);
      chk("r_src",   bus.vrf_src_o,         vreq_e & s);
      chk("r_id",    bus.vrf_id_o,          hd.id);
      chk("r_addr",  bus.vrf_addr_o,        hd.addr);
      chk("r_wdata", bus.vrf_wdata_o,       hd.wdata);
      chk("r_be",    bus.vrf_be_o,          hd.be);
      chk("r_acnt",  bus.alu_cnt_o,         rst ? 0 : aq.size());
      chk("r_mcnt",  bus.mfpu_cnt_o,        rst ? 0 : mq.size());
      if (rst) begin
        aq.delete(); mq.delete(); rr_m = 0; held_m = 0;
      end else begin
        other_ne = s ? (aq.size() > 0) : (mq.size() > 0);
        if (vreq_e && bus.vrf_gnt_i) begin
          if (s) void'(mq.pop_front()); else void'(aq.pop_front());
          if (other_ne) rr_m = ~s;
        end
        held_m = vreq_e && !bus.vrf_gnt_i;
        held_src_m = s;
        if (agnt_e) aq.push_back(a_in);
        if (mgnt_e) mq.push_back(m_in);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
